mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter: four requesters share one 4:1 data mux, with the
// select locked per packet and a registered valid/ready output stage.

module mux_rr_arbiter_lane #(
   parameter int         WIDTH = 4,
   parameter logic [1:0] LANE  = 2'd0
) (
   input  logic [1:0]       grant,
   input  logic             accept,
   input  logic [WIDTH-1:0] data,
   output logic             ready,
   output logic [WIDTH-1:0] data_sel
);
   logic hit;

   assign hit      = (grant == LANE);
   assign ready    = accept && hit;
   // AND-OR mux slice: only the granted lane contributes to the shared bus
   assign data_sel = hit ? data : '0;
endmodule

module mux_rr_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req_valid,
   input  logic [3:0]       req_last,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   input  logic [WIDTH-1:0] req_data2,
   input  logic [WIDTH-1:0] req_data3,
   output logic [3:0]       req_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic [1:0]       grant
);
   localparam int NUM_LANES = 4;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                              state;
   logic [1:0]                          ptr;
   logic [NUM_LANES-1:0][WIDTH-1:0]     lane_data;
   logic [NUM_LANES-1:0][WIDTH-1:0]     lane_sel;
   logic [WIDTH-1:0]                    mux_data;
   logic                                accept;
   logic                                xfer;
   logic                                any_req;
   logic [1:0]                          winner;
   logic [1:0]                          idx;
   logic                                found;

   assign lane_data[0] = req_data0;
   assign lane_data[1] = req_data1;
   assign lane_data[2] = req_data2;
   assign lane_data[3] = req_data3;

   assign busy    = (state == BUSY);
   // ready depends only on state/grant/output stage, never on req_valid
   assign accept  = (state == BUSY) && (!out_valid || out_ready);
   assign xfer    = accept && req_valid[grant];
   assign any_req = |req_valid;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mux_rr_arbiter_lane #(
         .WIDTH (WIDTH),
         .LANE  (2'(i))
      ) u_lane (
         .grant    (grant),
         .accept   (accept),
         .data     (lane_data[i]),
         .ready    (req_ready[i]),
         .data_sel (lane_sel[i])
      );
   end

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < NUM_LANES; i++) mux_data = mux_data | lane_sel[i];
   end

   // first valid requester scanning from ptr upward, wrapping mod 4
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = ptr + 2'(k);
         if (!found && req_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         grant     <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 2'd0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant <= winner;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (xfer && req_last[grant]) begin
                  state <= IDLE;
                  ptr   <= grant + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase

         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= grant;
            out_last  <= req_last[grant];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized packets checked
// against a transaction-level round-robin model.

module tb_mux_rr_arbiter;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] data;
      logic [1:0]   src;
      logic         last;
   } beat_t;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_last;
   logic [W-1:0] rd [4];
   logic [3:0]   req_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_src;
   logic         out_last;
   logic         out_ready;
   logic         busy;
   logic [1:0]   grant;

   int n_run  = 0;
   int n_fail = 0;

   beat_t      mon_q [$];
   logic [3:0] hs;
   int         pend [4];

   mux_rr_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data0 (rd[0]),
      .req_data1 (rd[1]),
      .req_data2 (rd[2]),
      .req_data3 (rd[3]),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .grant     (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change at posedge+2, so the falling edge sees what the next rising edge uses
   always @(negedge clk) begin
      hs = req_valid & req_ready;
      if (rst_n && out_valid && out_ready) mon_q.push_back('{out_data, out_src, out_last});
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      req_last = '0;
      out_ready = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      mon_q.delete();
   endtask

   // single-beat packets from pend[] until nbeats output beats are collected
   task automatic run_single(input int nbeats, input int budget, output bit tmo);
      int c;
      c = 0;
      tmo = 1'b0;
      forever begin
         for (int i = 0; i < 4; i++) begin
            req_valid[i] = (pend[i] > 0);
            req_last[i]  = 1'b1;
         end
         cyc();
         for (int i = 0; i < 4; i++) if (hs[i]) pend[i]--;
         if (mon_q.size() >= nbeats) break;
         c++;
         if (c > budget) begin
            tmo = 1'b1;
            break;
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      n_run++;
      if ({req_ready, out_valid, out_data, out_src, out_last, busy, grant} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b ov=%b od=%h src=%0d last=%b busy=%b grant=%0d, want all 0",
                  req_ready, out_valid, out_data, out_src, out_last, busy, grant);
      end
      rst_n = 1'b1;
      cyc();
      rd[1] = 8'h03;
      req_valid = 4'b0010;
      req_last = 4'b0000;
      cyc();
      cyc();
      #1;
      n_run++;
      if (!(busy === 1'b1 && out_valid === 1'b1)) begin
         n_fail++;
         $display("FAIL pre_reset_active: got busy=%b ov=%b, want 1 1", busy, out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_run++;
      if ({req_ready, out_valid, out_data, out_src, out_last, busy, grant} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got rdy=%b ov=%b od=%h src=%0d last=%b busy=%b grant=%0d, want all 0",
                  req_ready, out_valid, out_data, out_src, out_last, busy, grant);
      end
      req_valid = '0;
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      n_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_quiet: got ov=%b busy=%b, want 0 0", out_valid, busy);
      end
      rd[2] = 8'h05;
      req_valid = 4'b0100;
      req_last = 4'b0100;
      #1;
      n_run++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_cycle0: got rdy=%b busy=%b, want 0000 0", req_ready, busy);
      end
      cyc();
      #1;
      n_run++;
      if (busy !== 1'b1 || grant !== 2'd2 || req_ready !== 4'b0100 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_cycle1: got busy=%b grant=%0d rdy=%b ov=%b, want 1 2 0100 0",
                  busy, grant, req_ready, out_valid);
      end
      cyc();
      req_valid = '0;
      #1;
      n_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h05 || out_src !== 2'd2 || out_last !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_cycle2: got ov=%b od=%h src=%0d last=%b busy=%b, want 1 05 2 1 0",
                  out_valid, out_data, out_src, out_last, busy);
      end
      cyc();
      cyc();
   endtask

   task automatic test_round_robin();
      bit tmo;
      int exp_src [5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) rd[i] = W'(i + 10);
      pend = '{2, 1, 1, 1};
      run_single(5, 60, tmo);
      n_run++;
      if (tmo) begin
         n_fail++;
         $display("FAIL rr_timeout: got %0d beats, want 5", mon_q.size());
      end
      for (int k = 0; k < 5; k++) begin
         if (k < mon_q.size()) begin
            n_run++;
            if (mon_q[k].src !== 2'(exp_src[k]) || mon_q[k].data !== W'(exp_src[k] + 10)) begin
               n_fail++;
               $display("FAIL rr_beat%0d: got src=%0d data=%h, want src=%0d data=%h",
                        k, mon_q[k].src, mon_q[k].data, exp_src[k], exp_src[k] + 10);
            end
         end
      end
      cyc();
      cyc();
   endtask

   task automatic test_lock();
      int b, gap, c;
      bit done0;
      beat_t exp_b [4];
      b = 0;
      gap = 0;
      c = 0;
      done0 = 1'b0;
      do_reset();
      rd[0] = 8'h09;
      rd[1] = 8'h01;
      req_last = 4'b0001;
      req_valid = 4'b0010;
      while (mon_q.size() < 4 && c < 60) begin
         cyc();
         c++;
         if (hs[1]) begin
            b++;
            if (b == 1) gap = 2;
         end
         if (hs[0]) done0 = 1'b1;
         req_valid[0] = !done0;
         if (gap > 0) begin
            req_valid[1] = 1'b0;
            gap--;
         end else begin
            req_valid[1] = (b < 3);
         end
         rd[1] = W'(b + 1);
         req_last[1] = (b == 2);
         #1;
         if (!req_valid[1] && b > 0 && b < 3) begin
            n_run++;
            if (busy !== 1'b1 || grant !== 2'd1 || req_ready[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL lock_hold: got busy=%b grant=%0d rdy=%b, want 1 1 rdy0=0", busy, grant, req_ready);
            end
         end
      end
      req_valid = '0;
      exp_b = '{'{8'h01, 2'd1, 1'b0}, '{8'h02, 2'd1, 1'b0}, '{8'h03, 2'd1, 1'b1}, '{8'h09, 2'd0, 1'b1}};
      n_run++;
      if (mon_q.size() != 4) begin
         n_fail++;
         $display("FAIL lock_count: got %0d beats, want 4", mon_q.size());
      end
      for (int k = 0; k < 4; k++) begin
         if (k < mon_q.size()) begin
            n_run++;
            if (mon_q[k] !== exp_b[k]) begin
               n_fail++;
               $display("FAIL lock_beat%0d: got data=%h src=%0d last=%b, want data=%h src=%0d last=%b",
                        k, mon_q[k].data, mon_q[k].src, mon_q[k].last, exp_b[k].data, exp_b[k].src, exp_b[k].last);
            end
         end
      end
      cyc();
      cyc();
   endtask

   task automatic test_backpressure();
      int b;
      b = 0;
      do_reset();
      rd[2] = 8'h21;
      req_last = 4'b0000;
      req_valid = 4'b0100;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         if (hs[2]) b++;
         req_valid[2] = (b < 2);
         rd[2] = (b == 0) ? 8'h21 : 8'h22;
         req_last[2] = (b == 1);
         out_ready = !(c >= 2 && c <= 6);
         #1;
         if (c >= 2 && c <= 6) begin
            n_run++;
            if (out_valid !== 1'b1 || out_data !== 8'h21 || req_ready !== 4'b0000) begin
               n_fail++;
               $display("FAIL bp_hold_c%0d: got ov=%b od=%h rdy=%b, want 1 21 0000", c, out_valid, out_data, req_ready);
            end
         end
         if (c == 7) begin
            n_run++;
            if (req_ready !== 4'b0100) begin
               n_fail++;
               $display("FAIL bp_release: got rdy=%b, want 0100", req_ready);
            end
         end
      end
      req_valid = '0;
      out_ready = 1'b1;
      n_run++;
      if (mon_q.size() != 2) begin
         n_fail++;
         $display("FAIL bp_count: got %0d beats, want 2", mon_q.size());
      end else begin
         n_run++;
         if (mon_q[0] !== '{8'h21, 2'd2, 1'b0} || mon_q[1] !== '{8'h22, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_data: got %h/%b %h/%b, want 21/0 22/1",
                     mon_q[0].data, mon_q[0].last, mon_q[1].data, mon_q[1].last);
         end
      end
   endtask

   task automatic test_wrap();
      bit tmo;
      do_reset();
      for (int i = 0; i < 4; i++) rd[i] = W'(i + 10);
      pend = '{0, 0, 1, 0};
      run_single(1, 30, tmo);
      pend = '{1, 0, 0, 1};
      run_single(3, 30, tmo);
      n_run++;
      if (mon_q.size() < 3) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d beats, want 3", mon_q.size());
      end else begin
         n_run++;
         if (mon_q[0].src !== 2'd2 || mon_q[1].src !== 2'd3 || mon_q[2].src !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_order: got %0d,%0d,%0d, want 2,3,0", mon_q[0].src, mon_q[1].src, mon_q[2].src);
         end
      end
      cyc();
      cyc();
   endtask

   task automatic test_single_beat();
      do_reset();
      pend = '{4, 0, 0, 0};
      rd[0] = 8'h3C;
      req_last = 4'b1111;
      req_valid = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         if (hs[0]) pend[0]--;
         req_valid[0] = (pend[0] > 0);
         #1;
         n_run++;
         if (busy !== 1'((c % 2) == 1) || out_valid !== 1'((c % 2) == 0)) begin
            n_fail++;
            $display("FAIL single_c%0d: got busy=%b ov=%b, want %b %b", c, busy, out_valid, (c % 2) == 1, (c % 2) == 0);
         end
      end
      req_valid = '0;
      cyc();
      n_run++;
      if (mon_q.size() != 4) begin
         n_fail++;
         $display("FAIL single_count: got %0d beats, want 4", mon_q.size());
      end
   endtask

   task automatic test_random();
      beat_t sq [4][$];
      beat_t exp_q [$];
      int    pos [4];
      int    np, len, ptr, w, c;
      bit    first;
      logic  p_ov, p_ordy;
      beat_t p_beat;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         np = $urandom_range(2, 4);
         for (int p = 0; p < np; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) sq[i].push_back('{W'($urandom), 2'(i), (k == len - 1)});
         end
         pos[i] = 0;
      end
      // model: each IDLE picks the first requester with packets left, scanning from ptr
      for (int i = 0; i < 4; i++) pos[i] = 0;
      ptr = 0;
      forever begin
         w = -1;
         for (int k = 0; k < 4; k++)
            if (w < 0 && pos[(ptr + k) % 4] < sq[(ptr + k) % 4].size()) w = (ptr + k) % 4;
         if (w < 0) break;
         forever begin
            exp_q.push_back(sq[w][pos[w]]);
            pos[w]++;
            if (sq[w][pos[w] - 1].last) break;
         end
         ptr = (w + 1) % 4;
      end
      for (int i = 0; i < 4; i++) pos[i] = 0;
      p_ov = 1'b0;
      p_ordy = 1'b1;
      p_beat = '0;
      c = 0;
      while (mon_q.size() < exp_q.size() && c < 4000) begin
         for (int i = 0; i < 4; i++) begin
            if (pos[i] < sq[i].size()) begin
               first = (pos[i] == 0) || sq[i][pos[i] - 1].last;
               req_valid[i] = first || ($urandom_range(0, 3) != 0);
               rd[i] = sq[i][pos[i]].data;
               req_last[i] = sq[i][pos[i]].last;
            end else begin
               req_valid[i] = 1'b0;
               req_last[i] = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_run++;
         if (!$onehot0(req_ready)) begin
            n_fail++;
            $display("FAIL rnd_ready_onehot: got %b, want at most one bit", req_ready);
         end
         if (p_ov && !p_ordy) begin
            n_run++;
            if (out_valid !== 1'b1 || {out_data, out_src, out_last} !== p_beat) begin
               n_fail++;
               $display("FAIL rnd_stable: got ov=%b %h/%0d/%b, want 1 %h/%0d/%b",
                        out_valid, out_data, out_src, out_last, p_beat.data, p_beat.src, p_beat.last);
            end
         end
         p_ov = out_valid;
         p_ordy = out_ready;
         p_beat = '{out_data, out_src, out_last};
         cyc();
         for (int i = 0; i < 4; i++) if (hs[i]) pos[i]++;
         c++;
      end
      req_valid = '0;
      out_ready = 1'b1;
      repeat (4) cyc();
      n_run++;
      if (mon_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rnd_count: got %0d beats, want %0d", mon_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < mon_q.size()) begin
            n_run++;
            if (mon_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL rnd_beat%0d: got %h/%0d/%b, want %h/%0d/%b", k,
                        mon_q[k].data, mon_q[k].src, mon_q[k].last, exp_q[k].data, exp_q[k].src, exp_q[k].last);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0;
      req_last = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) rd[i] = '0;
      test_reset();
      test_round_robin();
      test_lock();
      test_backpressure();
      test_wrap();
      test_single_beat();
      for (int r = 0; r < 5; r++) test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
